// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// master is the loader side; slave is the byte source plus the memory.
interface instr_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 18
);
    // A byte moves on a rising clk edge when byte_valid && byte_ready are both high.
    // The source holds byte_data stable while byte_valid is high without ready,
    // and ready never depends on byte_data.
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: packs a byte stream three bytes per 18-bit word and writes
// the words to instruction memory from address 0 while holding the core off.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8:0]           word_count,
    input  logic                 abort,
    instr_loader_if.master       bus,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [8:0]        count_q;
    logic [8:0]        written_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] word_q;
    logic [1:0]        idx_q;

    logic [8:0]        sat_count;
    logic              ready;
    logic              we;
    logic              xfer;
    logic              last_write;
    logic              load_start;

    assign sat_count  = (word_count > 9'd256) ? 9'd256 : word_count;
    assign load_start = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        we         = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;
        last_write = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (sat_count == 9'd0) ? DONE : RECV;
                end
            end
            RECV: begin
                ready = 1'b1;
                xfer  = bus.byte_valid;
                if (xfer && (idx_q == 2'd2)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                we         = 1'b1;
                last_write = ((written_q + 9'd1) == count_q);
                next_state = last_write ? DONE : RECV;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // abort wins over any byte transfer, write or completion in the same cycle
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
            ready      = 1'b0;
            we         = 1'b0;
            done       = 1'b0;
            xfer       = 1'b0;
            last_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= 9'd0;
            written_q <= 9'd0;
            addr_q    <= '0;
            word_q    <= '0;
            idx_q     <= 2'd0;
        end else begin
            if (load_start) begin
                count_q   <= sat_count;
                written_q <= 9'd0;
                addr_q    <= '0;
                idx_q     <= 2'd0;
            end
            if (xfer) begin
                case (idx_q)
                    2'd0:    word_q[DATA_W-1:16] <= bus.byte_data[1:0];
                    2'd1:    word_q[15:8]        <= bus.byte_data;
                    default: word_q[7:0]         <= bus.byte_data;
                endcase
                idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
            // the address parks on the final word instead of wrapping past 255
            if (we) begin
                written_q <= written_q + 9'd1;
                if (!last_write) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign bus.byte_ready = ready;
    assign bus.mem_we     = we;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = word_q;
    assign busy           = (state != IDLE);
    assign cpu_hold       = (state != IDLE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader with a word-level reference model.
module tb_instr_loader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] word_count = 9'd0;
    logic       busy;
    logic       cpu_hold;
    logic       done;
    logic [1:0] state_dbg;

    instr_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: {addr, data} of every write the model predicts
    logic [25:0] exp_q[$];
    logic [7:0]  src_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int last_third = -100;
    int last_we = -100;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_n = 0;
    int busy_n = 0;
    int hold_n = 0;
    int exp_words = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_we"},    32'(bus.mem_we),     32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr),   32'd0);
        check({tag, "_wdata"}, 32'(bus.mem_wdata),  32'd0);
        check({tag, "_busy"},  32'(busy),           32'd0);
        check({tag, "_hold"},  32'(cpu_hold),       32'd0);
        check({tag, "_done"},  32'(done),           32'd0);
    endtask

    // One clock: sample on the falling edge, then return just after the rising edge.
    task automatic tick();
        logic        fire;
        logic [25:0] e;
        @(negedge clk);
        cyc++;
        fire = bus.byte_valid && bus.byte_ready;
        if (fire) begin
            acc++;
            if ((acc % 3) == 0) last_third = cyc;
        end
        if (start && !busy) start_cyc = cyc;
        if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr",  32'(bus.mem_addr),  32'(e[25:18]));
                check("write_data",  32'(bus.mem_wdata), 32'(e[17:0]));
                check("write_delay", 32'(cyc - last_third), 32'd1);
            end
            last_we = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
            if (exp_words > 0) check("done_after_write", 32'(cyc - last_we), 32'd1);
        end
        if (busy) busy_n++;
        if (cpu_hold) hold_n++;
        @(posedge clk);
        #1;
        if (fire) void'(src_q.pop_front());
    endtask

    // driver: mode 0 = valid held high, 1 = toggling, 2 = random
    task automatic drive_valid(input int mode);
        if (src_q.size() == 0) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom_range(0, 255));
        end else begin
            case (mode)
                0:       bus.byte_valid = 1'b1;
                1:       bus.byte_valid = ~bus.byte_valid;
                default: bus.byte_valid = 1'($urandom_range(0, 1));
            endcase
            bus.byte_data = src_q[0];
        end
    endtask

    // stop_at > 0 interrupts the load (abort, or reset when use_reset) after that many bytes
    task automatic do_load(input int count, input int nbytes, input int mode,
                           input int stop_at, input bit use_reset, input bit fixed_stream);
        int         sat;
        int         words;
        int         nint;
        int         timer;
        int         done0;
        int         busy0;
        int         hold0;
        bit         stopped;
        logic [7:0] fixed_b[6];
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        fixed_b = '{8'h02, 8'hAB, 8'hCD, 8'h01, 8'h12, 8'h34};
        sat = (count > 256) ? 256 : count;
        src_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            if (fixed_stream && i < 6) src_q.push_back(fixed_b[i]);
            else src_q.push_back(8'($urandom_range(0, 255)));
        end
        nint  = (stop_at > 0) ? stop_at : nbytes;
        words = ((nint / 3) < sat) ? (nint / 3) : sat;
        for (int i = 0; i < words; i++) begin
            b0 = src_q[3*i];
            b1 = src_q[3*i+1];
            b2 = src_q[3*i+2];
            exp_q.push_back({8'(i), b0[1:0], b1, b2});
        end
        exp_words  = words;
        acc        = 0;
        last_third = -100;
        last_we    = -100;
        done0      = done_n;
        busy0      = busy_n;
        hold0      = hold_n;
        stopped    = 1'b0;
        timer      = 0;

        start      = 1'b1;
        word_count = 9'(count);
        drive_valid(mode);
        tick();
        start = 1'b0;
        forever begin
            if (!stopped && stop_at > 0 && acc == stop_at) begin
                stopped = 1'b1;
                if (use_reset) begin
                    #2 reset = 1'b0;
                    #1 check_reset_values("midload_reset");
                    tick();
                    tick();
                    reset = 1'b1;
                end else begin
                    abort = 1'b1;
                    drive_valid(mode);
                    tick();
                    abort = 1'b0;
                    check("abort_idle", 32'(busy), 32'd0);
                end
                break;
            end
            if (stop_at == 0 && done_n != done0) break;
            if (timer >= 5000) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
            drive_valid(mode);
            tick();
            timer++;
        end
        for (int i = 0; i < 3; i++) begin
            drive_valid(mode);
            tick();
        end
        bus.byte_valid = 1'b0;
        check("writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (stop_at == 0) begin
            check("done_pulses", 32'(done_n - done0), 32'd1);
            check("ready_idle", 32'(bus.byte_ready), 32'd0);
            check("bytes_left", 32'(src_q.size()), 32'(nbytes - 3*sat));
            if (mode == 0) begin
                check("load_latency", 32'(done_cyc - start_cyc), 32'(4*sat + 1));
                check("busy_cycles",  32'(busy_n - busy0), 32'(4*sat + 1));
                check("hold_cycles",  32'(hold_n - hold0), 32'(4*sat + 1));
            end
        end else begin
            check("no_done", 32'(done_n - done0), 32'd0);
            check("idle_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #1 check_reset_values("por");
        #20 reset = 1'b1;
        tick();

        do_load(2, 6, 0, 0, 1'b0, 1'b1);
        do_load(2, 6, 1, 0, 1'b0, 1'b1);
        do_load(300, 771, 0, 0, 1'b0, 1'b0);
        do_load(0, 3, 0, 0, 1'b0, 1'b0);
        do_load(3, 9, 0, 4, 1'b0, 1'b0);
        do_load(1, 3, 2, 0, 1'b0, 1'b0);
        do_load(2, 6, 0, 5, 1'b1, 1'b0);
        do_load(1, 3, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            cnt = $urandom_range(0, 12);
            do_load(cnt, 3*cnt + $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
